// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, width and divide-by-zero constants for the calculator
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  localparam int CALC_WIDTH = 4;

  localparam logic [2*CALC_WIDTH-1:0] CALC_DIV_ZERO_RESULT = '1;

endpackage

// File: rtl/calc_divider.sv
// rtl/calc_divider.sv - combinational unsigned restoring divider with divide-by-zero flag
module calc_divider import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero
);

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;

  // One restoring step per quotient bit, MSB first; the remainder never exceeds the divisor.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem    = rem - {1'b0, divisor};
        quo[i] = 1'b1;
      end
    end
  end

  assign quotient = quo;
  assign div_zero = (divisor == '0);

endmodule

// File: rtl/calculator.sv
// rtl/calculator.sv - registered add/sub/mul/div unit; divider present only with CALC_DIV_EN
module calculator import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         op,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  output logic               div_zero
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] result_d, result_q;
  logic               out_valid_d, out_valid_q;
  logic               div_zero_d, div_zero_q;

  assign a_ext = {{WIDTH{1'b0}}, A};
  assign b_ext = {{WIDTH{1'b0}}, B};

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;

  calc_divider #(.WIDTH(WIDTH)) u_divider (
    .dividend (A),
    .divisor  (B),
    .quotient (quotient),
    .div_zero (div_by_zero)
  );
`endif

  always_comb begin
    result_d    = result_q;
    div_zero_d  = div_zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      div_zero_d = 1'b0;
      case (calc_op_e'(op))
        OP_ADD: result_d = a_ext + b_ext;
        OP_SUB: result_d = a_ext - b_ext;
        OP_MUL: result_d = a_ext * b_ext;
        OP_DIV: begin
`ifdef CALC_DIV_EN
          if (div_by_zero) begin
            result_d   = (2*WIDTH)'($signed(CALC_DIV_ZERO_RESULT));
            div_zero_d = 1'b1;
          end else begin
            result_d = {{WIDTH{1'b0}}, quotient};
          end
`else
          result_d = '0;
`endif
        end
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_calculator.sv
// tb/tb_calculator.sv - randomized and directed checks of calculator against an arithmetic model
module tb_calculator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] op;
  logic [7:0] result;
  logic       out_valid;
  logic       div_zero;

  int checks = 0;
  int errors = 0;
  int exp_res = 0;
  int exp_dz  = 0;

  calculator #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .op        (op),
    .result    (result),
    .out_valid (out_valid),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input int a, input int b, input int o,
                                output int res, output int dz);
    dz = 0;
    case (o)
      0: res = a + b;
      1: res = (a - b + 256) % 256;
      2: res = a * b;
      default: begin
`ifdef CALC_DIV_EN
        if (b == 0) begin
          res = 255;
          dz  = 1;
        end else begin
          res = a / b;
        end
`else
        res = 0;
`endif
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag, input int ov);
    check({tag, ".result"}, {24'h0, result}, exp_res);
    check({tag, ".out_valid"}, {31'h0, out_valid}, ov);
    check({tag, ".div_zero"}, {31'h0, div_zero}, exp_dz);
  endtask

  task automatic req(input int a, input int b, input int o);
    @(negedge clk);
    A        = 4'(a);
    B        = 4'(b);
    op       = 2'(o);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model(a, b, o, exp_res, exp_dz);
    check_outs($sformatf("req %0d op%0d %0d", a, o, b), 1);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    A        = 4'($urandom);
    B        = 4'($urandom);
    op       = 2'($urandom);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outs(tag, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    op       = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A        = 4'($urandom);
      B        = 4'($urandom);
      op       = 2'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_outs($sformatf("reset_hold%0d", i), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    req(4, 5, 0);
    req(6, 5, 1);
    req(5, 4, 2);
    req(8, 2, 3);

    req(15, 15, 0);
    req(15, 15, 2);
    req(3, 5, 1);
    req(7, 2, 3);
    req(0, 7, 3);

    req(9, 0, 3);
    req(1, 1, 0);

    req(4, 5, 0);
    for (int i = 0; i < 3; i++) idle($sformatf("hold%0d", i));

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) == 0) idle($sformatf("rand_idle%0d", i));
      else req(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(3, 0)));
    end

    req(5, 4, 2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_res = 0;
    exp_dz  = 0;
    check_outs("async_reset", 0);

    @(negedge clk);
    A        = 4'd9;
    B        = 4'd0;
    op       = 2'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_outs("reset_inflight", 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after_release", 0);

    req(15, 0, 0);
    req(0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calculator.md
# calculator

Registered 4-bit integer arithmetic unit: add, subtract, multiply or divide two unsigned operands selected by a 2-bit opcode, with an 8-bit result. Sits as a leaf datapath block behind a simple valid-qualified request interface; one operation accepted per clock, result available one cycle later.

## Interface
- WIDTH, default 4: operand width in bits; result width is 2*WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request qualifier; A, B, op are sampled when high.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- op  input  2  opcode: 00 add, 01 subtract, 10 multiply, 11 divide.
- result  output  2*WIDTH  registered result.
- out_valid  output  1  high for exactly one cycle per accepted request.
- div_zero  output  1  registered flag: accepted request was a divide with B == 0.

## Operation
- Both operands are unsigned and zero-extended to 2*WIDTH before the operation.
- op 00: result = A + B; max 30 at WIDTH=4, so no overflow.
- op 01: result = (A - B) mod 2^(2*WIDTH). A < B yields the two's-complement wrap, e.g. 3-5 = 8'hFE.
- op 10: result = A * B, full-width product; max 225, so no overflow.
- op 11: result = floor(A / B) in the low bits, upper bits zero.
- Divide by zero: result = all ones (8'hFF), div_zero = 1.
- div_zero = 0 for every other accepted request.
- in_valid low: result and div_zero hold their last values; out_valid = 0.
- No back-pressure. Every in_valid cycle is accepted.

## Timing
- Latency 1: request sampled at edge N gives result, div_zero and out_valid = 1 after edge N.
- Back-to-back requests give back-to-back results, one per cycle.
- Reset values: result = 0, out_valid = 0, div_zero = 0. They apply immediately on rst_n low, independent of clk.
- Reset asserted mid-operation: the in-flight request is dropped and out_valid = 0.
- First request is accepted on the first rising edge with rst_n high.
- All arithmetic is combinational between the input sample and the output register; no multi-cycle paths.

## Configuration
- CALC_DIV_EN defined: the divider is instantiated and op 11 behaves as above.
- CALC_DIV_EN undefined: no divider hardware.
  - op 11 gives result = 0 and div_zero = 0, with out_valid asserted normally.
  - Ops 00, 01, 10 are unchanged.

## Structure
- Package calc_pkg holds:
  - the opcode enum: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
  - the default WIDTH constant;
  - the divide-by-zero result constant (all ones).
- Sub-module calc_divider: combinational unsigned restoring divider, WIDTH-bit quotient, with a divide-by-zero output. Instantiated only under CALC_DIV_EN.
- Top level: opcode mux plus output registers.

## Test plan
- Reset: hold rst_n low with random inputs -> result 0, out_valid 0, div_zero 0. Assert rst_n asynchronously mid-cycle -> outputs clear immediately.
- Directed ops, one per cycle with in_valid high:
  - A=4, B=5, op=00 -> 9
  - A=6, B=5, op=01 -> 1
  - A=5, B=4, op=10 -> 20
  - A=8, B=2, op=11 -> 4
  - Each with out_valid pulsing the cycle after.
- Boundaries:
  - 15+15 -> 30
  - 15*15 -> 225
  - 3-5 -> 8'hFE
  - 7/2 -> 3
  - 0/7 -> 0
- Divide by zero: A=9, B=0, op=11 -> result 8'hFF, div_zero 1. Next request 1+1 -> 2, div_zero 0.
- Hold behaviour: drop in_valid for 3 cycles after 4+5 -> result stays 9, out_valid 0 throughout.
- Build without CALC_DIV_EN: A=8, B=2, op=11 -> result 0, div_zero 0; add, sub and mul vectors unchanged.
